// File: rtl/riscv_pkg.sv
// Shared constants and types for the fetch stage and its control-unit neighbours.
package riscv_pkg;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } fetch_state_t;

  // Control-unit outputs that steer the next PC.
  typedef struct packed {
    logic halt;
    logic jalr;
    logic jal;
    logic branch;
  } ctrl_flags_t;

endpackage

// File: rtl/next_pc_sel.sv
// Fixed-priority next-PC selection (halt > JALR > JAL > Branch > pc+4) with misalignment check.
module next_pc_sel
  import riscv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] imm,
  input  logic [XLEN-1:0] alu_result,
  input  ctrl_flags_t     flags,
  output logic [XLEN-1:0] next_pc,
  output logic            misaligned
);

  localparam logic [XLEN-1:0] JALR_MASK = {{(XLEN-1){1'b1}}, 1'b0};

  always_comb begin
    // NOTE: every output gets a default first so no path through the block can infer a latch.
    next_pc    = pc + XLEN'(4);
    misaligned = 1'b0;
    if (flags.halt) begin
      next_pc = pc;
    end else if (flags.jalr) begin
      next_pc = alu_result & JALR_MASK;
    end else if (flags.jal || flags.branch) begin
      next_pc = pc + imm;
    end
    misaligned = (next_pc[1:0] != 2'b00);
  end

endmodule

// File: rtl/pc_fetch_unit.sv
// Program counter and fetch stage: owns the PC, qualifies fetched words, tracks halt/trap/retired.
module pc_fetch_unit
  import riscv_pkg::*;
#(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000,
  parameter int              CNT_W    = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  output logic [XLEN-1:0]  imem_addr,
  input  logic [31:0]      imem_rdata,
  input  logic             imem_valid,
  input  logic             Branch,
  input  logic             JALflag,
  input  logic             JALRflag,
  input  logic             halt,
  input  logic [XLEN-1:0]  imm,
  input  logic [XLEN-1:0]  alu_result,
  output logic [XLEN-1:0]  pc,
  output logic [XLEN-1:0]  pc_plus4,
  output logic [31:0]      instr,
  output logic             instr_valid,
  output logic             halted,
  output logic             trap_misaligned,
  output logic [CNT_W-1:0] retired
);

  fetch_state_t    state_q, state_d;
  logic [XLEN-1:0] pc_q;
  logic [CNT_W-1:0] retired_q;
  logic            trap_q;
  ctrl_flags_t     flags;
  logic [XLEN-1:0] next_pc;
  logic            misaligned;
  logic            fire;

  assign flags = '{halt: halt, jalr: JALRflag, jal: JALflag, branch: Branch};

  next_pc_sel #(.XLEN(XLEN)) u_next_pc_sel (
    .pc         (pc_q),
    .imm        (imm),
    .alu_result (alu_result),
    .flags      (flags),
    .next_pc    (next_pc),
    .misaligned (misaligned)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (!rst_n) state_q <= BOOT;
    else        state_q <= state_d;
  end

  // Next-state logic: a fired instruction that halts or traps ends the run for good.
  always_comb begin
    state_d = state_q;
    case (state_q)
      BOOT:    state_d = RUN;
      RUN:     if (fire && (flags.halt || misaligned)) state_d = HALT;
      HALT:    state_d = HALT;
      default: state_d = BOOT;
    endcase
  end

  // Output logic.
  always_comb begin
    fire        = 1'b0;
    instr_valid = 1'b0;
    instr       = NOP_INSTR;
    halted      = 1'b0;
    case (state_q)
      RUN: begin
        fire        = imem_valid;
        instr_valid = imem_valid;
        instr       = imem_valid ? imem_rdata : NOP_INSTR;
      end
      HALT:    halted = 1'b1;
      default: ;
    endcase
  end

  // PC only advances on an executed instruction that neither halts nor lands misaligned.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q <= RESET_PC;
    end else if (fire && !flags.halt && !misaligned) begin
      pc_q <= next_pc;
    end
  end

  // Retired counter saturates at all-ones rather than wrapping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      retired_q <= '0;
    end else if (fire && (retired_q != '1)) begin
      retired_q <= retired_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      trap_q <= 1'b0;
    end else if (fire && !flags.halt && misaligned) begin
      trap_q <= 1'b1;
    end
  end

  assign pc              = pc_q;
  assign imem_addr       = pc_q;
  assign pc_plus4        = pc_q + XLEN'(4);
  assign retired         = retired_q;
  assign trap_misaligned = trap_q;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Self-checking bench for pc_fetch_unit: directed scenarios plus randomized runs against a reference model.
module tb_pc_fetch_unit;
  import riscv_pkg::*;

  localparam int          XLEN    = 32;
  localparam int          CNT_W   = 4;
  localparam logic [31:0] RST_PC  = 32'h100;
  localparam int          RET_MAX = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [XLEN-1:0]  imem_addr;
  logic [31:0]      imem_rdata = '0;
  logic             imem_valid = 1'b0;
  logic             Branch = 1'b0, JALflag = 1'b0, JALRflag = 1'b0, halt = 1'b0;
  logic [XLEN-1:0]  imm = '0, alu_result = '0;
  logic [XLEN-1:0]  pc, pc_plus4;
  logic [31:0]      instr;
  logic             instr_valid, halted, trap_misaligned;
  logic [CNT_W-1:0] retired;

  int tests_run = 0;
  int tests_failed = 0;

  pc_fetch_unit #(.XLEN(XLEN), .RESET_PC(RST_PC), .CNT_W(CNT_W)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .imem_addr       (imem_addr),
    .imem_rdata      (imem_rdata),
    .imem_valid      (imem_valid),
    .Branch          (Branch),
    .JALflag         (JALflag),
    .JALRflag        (JALRflag),
    .halt            (halt),
    .imm             (imm),
    .alu_result      (alu_result),
    .pc              (pc),
    .pc_plus4        (pc_plus4),
    .instr           (instr),
    .instr_valid     (instr_valid),
    .halted          (halted),
    .trap_misaligned (trap_misaligned),
    .retired         (retired)
  );

  always #5 clk = ~clk;

  // Reference model: phase 0 = waiting one cycle after reset, 1 = running, 2 = stopped.
  int          m_phase;
  logic [31:0] m_pc;
  int          m_ret;
  logic        m_trap;

  function automatic void m_reset();
    m_phase = 0;
    m_pc    = RST_PC;
    m_ret   = 0;
    m_trap  = 1'b0;
  endfunction

  function automatic void m_step();
    logic [31:0] tgt;
    if (m_phase == 0) begin
      m_phase = 1;
      return;
    end
    if (m_phase != 1 || !imem_valid) return;
    if (m_ret < RET_MAX) m_ret = m_ret + 1;
    if (halt) begin
      m_phase = 2;
      return;
    end
    if (JALRflag)                tgt = {alu_result[31:1], 1'b0};
    else if (JALflag || Branch)  tgt = m_pc + imm;
    else                         tgt = m_pc + 32'd4;
    if (tgt % 4 != 0) begin
      m_phase = 2;
      m_trap  = 1'b1;
    end else begin
      m_pc = tgt;
    end
  endfunction

  task automatic drive(input logic v, input logic [31:0] rd, input logic br, input logic jl,
                       input logic jr, input logic hl, input logic [31:0] im, input logic [31:0] al);
    imem_valid = v;  imem_rdata = rd;
    Branch = br;  JALflag = jl;  JALRflag = jr;  halt = hl;
    imm = im;  alu_result = al;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic seq(input logic v);
    drive(v, 32'h0000_0093, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
  endtask

  // Leaves the DUT in its post-reset wait cycle, 1 time unit after a rising edge.
  task automatic do_reset();
    rst_n = 1'b0;
    seq(1'b0);
    tick();
    rst_n = 1'b1;
    m_reset();
  endtask

  task automatic boot();
    seq(1'b0);
    tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    drive(1'b1, 32'hDEAD_BEEF, 1'b1, 1'b1, 1'b1, 1'b0, 32'h8, 32'h400);
    tick();
    tick();
    tests_run++;
    if ({pc, retired, instr_valid, halted, trap_misaligned, instr} !==
        {RST_PC, 4'd0, 1'b0, 1'b0, 1'b0, NOP_INSTR}) begin
      tests_failed++;
      $display("FAIL reset_state: pc=%h ret=%0d iv=%b h=%b t=%b instr=%h, want pc=%h all clear",
               pc, retired, instr_valid, halted, trap_misaligned, instr, RST_PC);
    end
    rst_n = 1'b1;
    drive(1'b1, 32'h0050_0093, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    #1;
    tests_run++;
    if (instr_valid !== 1'b0 || instr !== NOP_INSTR || imem_addr !== RST_PC) begin
      tests_failed++;
      $display("FAIL boot_cycle: iv=%b instr=%h addr=%h, want 0/%h/%h",
               instr_valid, instr, imem_addr, NOP_INSTR, RST_PC);
    end
    tick();
    tests_run++;
    if (instr_valid !== 1'b1 || instr !== 32'h0050_0093 || imem_addr !== 32'h100) begin
      tests_failed++;
      $display("FAIL first_fetch: iv=%b instr=%h addr=%h, want 1/00500093/00000100",
               instr_valid, instr, imem_addr);
    end
    tick();
    tick();
    tick();
    tests_run++;
    if (pc !== 32'h10C || retired !== 4'd3) begin
      tests_failed++;
      $display("FAIL three_fetches: pc=%h ret=%0d, want 0000010c/3", pc, retired);
    end
  endtask

  task automatic test_stall();
    do_reset();
    boot();
    seq(1'b1);
    tick();
    tick();
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, $urandom, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), $urandom, $urandom);
      #1;
      tests_run++;
      if (instr !== NOP_INSTR || instr_valid !== 1'b0) begin
        tests_failed++;
        $display("FAIL stall_instr[%0d]: instr=%h iv=%b, want %h/0", i, instr, instr_valid, NOP_INSTR);
      end
      tick();
      tests_run++;
      if (pc !== 32'h108) begin
        tests_failed++;
        $display("FAIL stall_pc[%0d]: pc=%h, want 00000108", i, pc);
      end
    end
    tests_run++;
    if (retired !== 4'd2) begin
      tests_failed++;
      $display("FAIL stall_retired: ret=%0d, want 2", retired);
    end
    seq(1'b1);
    tick();
    tests_run++;
    if (pc !== 32'h10C || retired !== 4'd3) begin
      tests_failed++;
      $display("FAIL stall_resume: pc=%h ret=%0d, want 0000010c/3", pc, retired);
    end
  endtask

  task automatic test_jumps();
    do_reset();
    boot();
    drive(1'b1, 32'h0000_0067, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 32'h200);
    tick();
    drive(1'b1, 32'h0000_0063, 1'b1, 1'b0, 1'b0, 1'b0, 32'hFFFF_FFF8, 32'h0);
    tick();
    tests_run++;
    if (pc !== 32'h1F8) begin
      tests_failed++;
      $display("FAIL branch_back: pc=%h, want 000001f8", pc);
    end
    drive(1'b1, 32'h0000_006F, 1'b0, 1'b1, 1'b0, 1'b0, 32'h40, 32'h0);
    #1;
    tests_run++;
    if (pc_plus4 !== 32'h1FC) begin
      tests_failed++;
      $display("FAIL jal_link: pc_plus4=%h, want 000001fc", pc_plus4);
    end
    tick();
    tests_run++;
    if (pc !== 32'h238 || pc_plus4 !== 32'h23C) begin
      tests_failed++;
      $display("FAIL jal_target: pc=%h pc_plus4=%h, want 00000238/0000023c", pc, pc_plus4);
    end
    drive(1'b1, 32'h0000_0067, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 32'h301);
    tick();
    tests_run++;
    if (pc !== 32'h300) begin
      tests_failed++;
      $display("FAIL jalr_lsb_clear: pc=%h, want 00000300", pc);
    end
    drive(1'b1, 32'h0000_0067, 1'b1, 1'b1, 1'b1, 1'b0, 32'h8, 32'h401);
    tick();
    tests_run++;
    if (pc !== 32'h400 || retired !== 4'd5) begin
      tests_failed++;
      $display("FAIL jalr_priority: pc=%h ret=%0d, want 00000400/5", pc, retired);
    end
  endtask

  task automatic test_halt();
    do_reset();
    boot();
    drive(1'b1, 32'h0000_0067, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 32'h120);
    tick();
    drive(1'b1, 32'h0000_0073, 1'b0, 1'b1, 1'b0, 1'b1, 32'h8, 32'h0);
    #1;
    tests_run++;
    if (halted !== 1'b0 || instr_valid !== 1'b1) begin
      tests_failed++;
      $display("FAIL halt_same_cycle: h=%b iv=%b, want 0/1", halted, instr_valid);
    end
    tick();
    tests_run++;
    if ({halted, trap_misaligned, pc, retired} !== {1'b1, 1'b0, 32'h120, 4'd2}) begin
      tests_failed++;
      $display("FAIL halt_enter: h=%b t=%b pc=%h ret=%0d, want 1/0/00000120/2",
               halted, trap_misaligned, pc, retired);
    end
    for (int i = 0; i < 6; i++) begin
      drive(1'(i % 2 == 0), $urandom, 1'b1, 1'($urandom), 1'($urandom), 1'b0, 32'h10, 32'h500);
      #1;
      tests_run++;
      if (instr_valid !== 1'b0 || instr !== NOP_INSTR) begin
        tests_failed++;
        $display("FAIL halt_no_issue[%0d]: iv=%b instr=%h, want 0/%h", i, instr_valid, instr, NOP_INSTR);
      end
      tick();
      tests_run++;
      if ({halted, pc, retired} !== {1'b1, 32'h120, 4'd2}) begin
        tests_failed++;
        $display("FAIL halt_frozen[%0d]: h=%b pc=%h ret=%0d, want 1/00000120/2", i, halted, pc, retired);
      end
    end
  endtask

  task automatic test_misaligned();
    do_reset();
    boot();
    drive(1'b1, 32'h0000_006F, 1'b0, 1'b1, 1'b0, 1'b0, 32'h6, 32'h0);
    tick();
    tests_run++;
    if ({pc, halted, trap_misaligned, retired} !== {32'h100, 1'b1, 1'b1, 4'd1}) begin
      tests_failed++;
      $display("FAIL misaligned_jal: pc=%h h=%b t=%b ret=%0d, want 00000100/1/1/1",
               pc, halted, trap_misaligned, retired);
    end
    do_reset();
    boot();
    drive(1'b1, 32'h0000_0067, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 32'h303);
    tick();
    tests_run++;
    if ({pc, halted, trap_misaligned} !== {32'h100, 1'b1, 1'b1}) begin
      tests_failed++;
      $display("FAIL misaligned_jalr: pc=%h h=%b t=%b, want 00000100/1/1", pc, halted, trap_misaligned);
    end
  endtask

  task automatic test_wrap_and_async_reset();
    do_reset();
    boot();
    drive(1'b1, 32'h0000_0067, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 32'hFFFF_FFFC);
    tick();
    tests_run++;
    if (pc !== 32'hFFFF_FFFC || pc_plus4 !== 32'h0) begin
      tests_failed++;
      $display("FAIL wrap_link: pc=%h pc_plus4=%h, want fffffffc/00000000", pc, pc_plus4);
    end
    seq(1'b1);
    tick();
    tests_run++;
    if (pc !== 32'h0) begin
      tests_failed++;
      $display("FAIL wrap_pc: pc=%h, want 00000000", pc);
    end
    seq(1'b0);
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    tests_run++;
    if ({pc, retired, halted, instr_valid} !== {RST_PC, 4'd0, 1'b0, 1'b0}) begin
      tests_failed++;
      $display("FAIL async_reset: pc=%h ret=%0d h=%b iv=%b, want %h/0/0/0",
               pc, retired, halted, instr_valid, RST_PC);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_saturate();
    do_reset();
    boot();
    seq(1'b1);
    for (int i = 0; i < 20; i++) tick();
    tests_run++;
    if (retired !== 4'(RET_MAX) || pc !== 32'h150) begin
      tests_failed++;
      $display("FAIL retired_saturate: ret=%0d pc=%h, want %0d/00000150", retired, pc, RET_MAX);
    end
  endtask

  task automatic test_random();
    logic [134:0] obs, exp;
    logic         exp_valid;
    logic [31:0]  im, al;
    for (int ep = 0; ep < 10; ep++) begin
      do_reset();
      for (int cyc = 0; cyc < 40; cyc++) begin
        im = 32'($urandom_range(0, 511)) - 32'd256;
        if ($urandom_range(0, 19) != 0) im = im & ~32'h3;
        al = $urandom;
        if ($urandom_range(0, 9) != 0) al[1] = 1'b0;
        drive(1'($urandom_range(0, 3) != 0), $urandom, 1'($urandom_range(0, 3) == 0),
              1'($urandom_range(0, 4) == 0), 1'($urandom_range(0, 5) == 0),
              1'($urandom_range(0, 49) == 0), im, al);
        #1;
        exp_valid = (m_phase == 1) && imem_valid;
        exp = {m_pc, m_pc, m_pc + 32'd4, exp_valid ? imem_rdata : NOP_INSTR,
               exp_valid, 1'(m_phase == 2), m_trap, 4'(m_ret)};
        obs = {pc, imem_addr, pc_plus4, instr, instr_valid, halted, trap_misaligned, retired};
        tests_run++;
        if (obs !== exp) begin
          tests_failed++;
          $display("FAIL random[%0d.%0d]: got %h want %h (pc|addr|pc4|instr|iv|h|trap|ret)",
                   ep, cyc, obs, exp);
        end
        m_step();
        tick();
      end
    end
  endtask

  initial begin
    test_reset();
    test_stall();
    test_jumps();
    test_halt();
    test_misaligned();
    test_wrap_and_async_reset();
    test_saturate();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
